serial_deser_422: RTL and testbench

Parametrised multi-channel receiver for RS-422 style clock/enable/data serial links. Each channel synchronises its external CLK_IN, EN_IN and DATA_IN into the system clock domain and detects the selected edge of CLK_IN. It shifts DATA_IN into a WORD_W-bit word while EN_IN is high and emits the finished word with a one-cycle strobe. It replaces single-bit, single-channel front-ends by delivering whole words, selectable edge and bit order, and framing-error detection to the downstream SSD write logic.

---
 rtl/serial_deser_422.sv | 111 +++++++++++
 tb/tb_serial_deser_422.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deser_422.sv
// Multi-channel RS-422 clock/enable/data receiver.
// Each channel synchronises its link, shifts bits on the selected edge, emits words.
module serial_deser_422 #(
    parameter int CHANNELS    = 2,
    parameter int WORD_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1,
    parameter int EDGE_SEL    = 0
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic [CHANNELS-1:0]        CLK_IN,
    input  logic [CHANNELS-1:0]        EN_IN,
    input  logic [CHANNELS-1:0]        DATA_IN,
    output logic [CHANNELS*WORD_W-1:0] data_out,
    output logic [CHANNELS-1:0]        data_en,
    output logic [CHANNELS-1:0]        frame_err
);

    localparam int CW = $clog2(WORD_W + 1);
    localparam int AW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] LAST  = CW'(WORD_W - 1);
    localparam logic [AW-1:0] ARM_N = AW'(SYNC_STAGES + 1);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [SYNC_STAGES-1:0] clk_s;
        logic [SYNC_STAGES-1:0] en_s;
        logic [SYNC_STAGES-1:0] dat_s;
        logic                   clk_p;
        logic                   en_p;
        logic [AW-1:0]          arm_cnt;
        logic [WORD_W-1:0]      shift_q;
        logic [WORD_W-1:0]      shift_d;
        logic [WORD_W-1:0]      word_q;
        logic [CW-1:0]          cnt_q;
        logic                   den_q;
        logic                   ferr_q;
        logic                   clk_c;
        logic                   en_c;
        logic                   dat_c;
        logic                   armed;
        logic                   edge_ev;
        logic                   en_fall;

        assign clk_c   = clk_s[SYNC_STAGES-1];
        assign en_c    = en_s[SYNC_STAGES-1];
        assign dat_c   = dat_s[SYNC_STAGES-1];
        assign armed   = (arm_cnt == ARM_N);
        assign en_fall = en_p & ~en_c;

        // A level held through reset would look like an edge while the chain fills
        if (EDGE_SEL != 0) begin : g_fall
            assign edge_ev = armed & clk_p & ~clk_c;
        end else begin : g_rise
            assign edge_ev = armed & ~clk_p & clk_c;
        end

        if (MSB_FIRST != 0) begin : g_msb
            assign shift_d = {shift_q[WORD_W-2:0], dat_c};
        end else begin : g_lsb
            assign shift_d = {dat_c, shift_q[WORD_W-1:1]};
        end

        always_ff @(posedge clk) begin
            if (RST) begin
                clk_s   <= '0;
                en_s    <= '0;
                dat_s   <= '0;
                clk_p   <= 1'b0;
                en_p    <= 1'b0;
                arm_cnt <= '0;
                shift_q <= '0;
                word_q  <= '0;
                cnt_q   <= '0;
                den_q   <= 1'b0;
                ferr_q  <= 1'b0;
            end else begin
                clk_s  <= {clk_s[SYNC_STAGES-2:0], CLK_IN[n]};
                en_s   <= {en_s[SYNC_STAGES-2:0], EN_IN[n]};
                dat_s  <= {dat_s[SYNC_STAGES-2:0], DATA_IN[n]};
                clk_p  <= clk_c;
                en_p   <= en_c;
                den_q  <= 1'b0;
                ferr_q <= 1'b0;
                if (!armed) begin
                    arm_cnt <= arm_cnt + 1'b1;
                end
                if (en_fall) begin
                    if (cnt_q != '0) begin
                        ferr_q <= 1'b1;
                    end
                    cnt_q <= '0;
                end else if (edge_ev && en_c) begin
                    shift_q <= shift_d;
                    if (cnt_q == LAST) begin
                        word_q <= shift_d;
                        den_q  <= 1'b1;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end

        assign data_out[n*WORD_W +: WORD_W] = word_q;
        assign data_en[n]                   = den_q;
        assign frame_err[n]                 = ferr_q;
    end

endmodule

// File: tb/tb_serial_deser_422.sv
// Directed bench for serial_deser_422: MSB-first/rising instance A,
// LSB-first/falling instance B.
module tb_serial_deser_422;

    logic        clk;
    logic        RST;
    logic [1:0]  ca, ea, da, cb, eb, db;
    logic [15:0] do_a, do_b;
    logic [1:0]  den_a, fe_a, den_b, fe_b;
    logic [1:0]  den_a_d, den_b_d;
    int          den_n_a [2];
    int          fe_n_a  [2];
    int          den_n_b [2];
    int          fe_n_b  [2];
    int          consec;
    int          passed;
    int          total;

    serial_deser_422 #(
        .CHANNELS(2), .WORD_W(8), .SYNC_STAGES(2),
        .MSB_FIRST(1), .EDGE_SEL(0)
    ) dut_a (
        .clk(clk), .RST(RST),
        .CLK_IN(ca), .EN_IN(ea), .DATA_IN(da),
        .data_out(do_a), .data_en(den_a), .frame_err(fe_a)
    );

    serial_deser_422 #(
        .CHANNELS(2), .WORD_W(8), .SYNC_STAGES(2),
        .MSB_FIRST(0), .EDGE_SEL(1)
    ) dut_b (
        .clk(clk), .RST(RST),
        .CLK_IN(cb), .EN_IN(eb), .DATA_IN(db),
        .data_out(do_b), .data_en(den_b), .frame_err(fe_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        consec  = 0;
        den_a_d = '0;
        den_b_d = '0;
        for (int c = 0; c < 2; c++) begin
            den_n_a[c] = 0;
            fe_n_a[c]  = 0;
            den_n_b[c] = 0;
            fe_n_b[c]  = 0;
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (den_a[c] === 1'b1) den_n_a[c]++;
            if (fe_a[c] === 1'b1)  fe_n_a[c]++;
            if (den_b[c] === 1'b1) den_n_b[c]++;
            if (fe_b[c] === 1'b1)  fe_n_b[c]++;
        end
        if ((den_a & den_a_d) != 2'b00) consec++;
        if ((den_b & den_b_d) != 2'b00) consec++;
        den_a_d = den_a;
        den_b_d = den_b;
    end

    // Bit i on the wire is w[n-1-i]; hist holds data_en at the 4 negedges after the last active edge
    task automatic send(input bit b, input logic [1:0] m,
                        input logic [7:0] w0, input logic [7:0] w1,
                        input int n, output logic [7:0] hist);
        hist = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (b) begin
                cb = cb | m;
                if (m[0]) db[0] = w0[n-1-i];
                if (m[1]) db[1] = w1[n-1-i];
            end else begin
                ca = ca & ~m;
                if (m[0]) da[0] = w0[n-1-i];
                if (m[1]) da[1] = w1[n-1-i];
            end
            repeat (4) @(negedge clk);
            if (b) cb = cb & ~m;
            else   ca = ca | m;
            hist = '0;
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                hist[2*j +: 2] = b ? den_b : den_a;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        ca = 2'b11; ea = 2'b01; da = 2'b00;
        cb = 2'b11; eb = 2'b00; db = 2'b00;
        repeat (3) @(negedge clk);
        total++;
        if (do_a !== 16'h0000) $display("FAIL rst_do_a got %h want 0000", do_a);
        else passed++;
        total++;
        if (den_a !== 2'b00) $display("FAIL rst_den_a got %b want 00", den_a);
        else passed++;
        total++;
        if (fe_a !== 2'b00) $display("FAIL rst_fe_a got %b want 00", fe_a);
        else passed++;
        total++;
        if (do_b !== 16'h0000) $display("FAIL rst_do_b got %h want 0000", do_b);
        else passed++;
        RST = 1'b0;
        repeat (8) @(negedge clk);
        ea = 2'b00;
        repeat (8) @(negedge clk);
        total++;
        if (fe_n_a[0] !== 0) $display("FAIL arm_fe got %0d want 0", fe_n_a[0]);
        else passed++;
        total++;
        if (den_n_a[0] !== 0) $display("FAIL arm_den got %0d want 0", den_n_a[0]);
        else passed++;
    endtask

    task automatic test_basic();
        logic [7:0] h;
        int d0, d1, f0;
        d0 = den_n_a[0]; d1 = den_n_a[1]; f0 = fe_n_a[0];
        @(negedge clk) ea = 2'b01;
        repeat (4) @(negedge clk);
        send(1'b0, 2'b01, 8'hA5, 8'h00, 8, h);
        total++;
        if (h !== 8'h10) $display("FAIL basic_latency got %h want 10", h);
        else passed++;
        total++;
        if (do_a[7:0] !== 8'hA5) $display("FAIL basic_word got %h want a5", do_a[7:0]);
        else passed++;
        total++;
        if (do_a[15:8] !== 8'h00) $display("FAIL basic_ch1 got %h want 00", do_a[15:8]);
        else passed++;
        total++;
        if (den_n_a[0] - d0 !== 1) $display("FAIL basic_den0 got %0d want 1", den_n_a[0] - d0);
        else passed++;
        total++;
        if (den_n_a[1] - d1 !== 0) $display("FAIL basic_den1 got %0d want 0", den_n_a[1] - d1);
        else passed++;
        @(negedge clk) ea = 2'b00;
        repeat (6) @(negedge clk);
        total++;
        if (fe_n_a[0] - f0 !== 0) $display("FAIL basic_fe got %0d want 0", fe_n_a[0] - f0);
        else passed++;
    endtask

    task automatic test_lsb_falling();
        logic [7:0] h;
        int d0, f0;
        d0 = den_n_b[0]; f0 = fe_n_b[0];
        @(negedge clk) eb = 2'b01;
        repeat (4) @(negedge clk);
        send(1'b1, 2'b01, 8'h81, 8'h00, 8, h);
        total++;
        if (do_b[7:0] !== 8'h81) $display("FAIL lsb_word1 got %h want 81", do_b[7:0]);
        else passed++;
        send(1'b1, 2'b01, 8'h60, 8'h00, 8, h);
        total++;
        if (do_b[7:0] !== 8'h06) $display("FAIL lsb_word2 got %h want 06", do_b[7:0]);
        else passed++;
        @(negedge clk) eb = 2'b00;
        repeat (6) @(negedge clk);
        total++;
        if (den_n_b[0] - d0 !== 2) $display("FAIL lsb_den got %0d want 2", den_n_b[0] - d0);
        else passed++;
        total++;
        if (fe_n_b[0] - f0 !== 0) $display("FAIL lsb_fe got %0d want 0", fe_n_b[0] - f0);
        else passed++;
    endtask

    task automatic test_frame_err();
        logic [7:0] h;
        logic [7:0] fh;
        int d0, f0;
        d0 = den_n_a[0]; f0 = fe_n_a[0];
        @(negedge clk) ea = 2'b01;
        repeat (4) @(negedge clk);
        send(1'b0, 2'b01, 8'h16, 8'h00, 5, h);
        @(negedge clk) ea = 2'b00;
        fh = '0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            fh[2*j +: 2] = fe_a;
        end
        total++;
        if (fh !== 8'h10) $display("FAIL ferr_pulse got %h want 10", fh);
        else passed++;
        total++;
        if (den_n_a[0] - d0 !== 0) $display("FAIL ferr_den got %0d want 0", den_n_a[0] - d0);
        else passed++;
        total++;
        if (do_a[7:0] !== 8'hA5) $display("FAIL ferr_hold got %h want a5", do_a[7:0]);
        else passed++;
        @(negedge clk) ea = 2'b01;
        repeat (4) @(negedge clk);
        send(1'b0, 2'b01, 8'h3C, 8'h00, 8, h);
        @(negedge clk) ea = 2'b00;
        repeat (6) @(negedge clk);
        total++;
        if (do_a[7:0] !== 8'h3C) $display("FAIL ferr_next got %h want 3c", do_a[7:0]);
        else passed++;
        total++;
        if (fe_n_a[0] - f0 !== 1) $display("FAIL ferr_count got %0d want 1", fe_n_a[0] - f0);
        else passed++;
    endtask

    task automatic test_en_low();
        int d, f;
        d = den_n_a[0] + den_n_a[1];
        f = fe_n_a[0] + fe_n_a[1];
        ea = 2'b00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk) ca = ~ca;
            repeat (3) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        total++;
        if (den_n_a[0] + den_n_a[1] - d !== 0)
            $display("FAIL enlow_den got %0d want 0", den_n_a[0] + den_n_a[1] - d);
        else passed++;
        total++;
        if (fe_n_a[0] + fe_n_a[1] - f !== 0)
            $display("FAIL enlow_fe got %0d want 0", fe_n_a[0] + fe_n_a[1] - f);
        else passed++;
        total++;
        if (do_a !== 16'h003C) $display("FAIL enlow_hold got %h want 003c", do_a);
        else passed++;
    endtask

    task automatic test_reset_midword();
        logic [7:0] h;
        int f1;
        f1 = fe_n_a[1];
        @(negedge clk) ea = 2'b10;
        repeat (4) @(negedge clk);
        send(1'b0, 2'b10, 8'h00, 8'h0A, 4, h);
        @(negedge clk) RST = 1'b1;
        @(negedge clk);
        total++;
        if (do_a !== 16'h0000) $display("FAIL mid_rst_do got %h want 0000", do_a);
        else passed++;
        total++;
        if ({den_a, fe_a} !== 4'b0000) $display("FAIL mid_rst_strb got %b want 0000", {den_a, fe_a});
        else passed++;
        RST = 1'b0;
        repeat (8) @(negedge clk);
        ea = 2'b00;
        repeat (8) @(negedge clk);
        total++;
        if (fe_n_a[1] - f1 !== 0) $display("FAIL mid_no_ferr got %0d want 0", fe_n_a[1] - f1);
        else passed++;
        @(negedge clk) ea = 2'b10;
        repeat (4) @(negedge clk);
        send(1'b0, 2'b10, 8'h00, 8'hF0, 8, h);
        @(negedge clk) ea = 2'b00;
        repeat (6) @(negedge clk);
        total++;
        if (do_a !== 16'hF000) $display("FAIL mid_word got %h want f000", do_a);
        else passed++;
        total++;
        if (fe_n_a[1] - f1 !== 0) $display("FAIL mid_ferr_end got %0d want 0", fe_n_a[1] - f1);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] h;
        @(negedge clk) ea = 2'b11;
        repeat (4) @(negedge clk);
        send(1'b0, 2'b11, 8'h55, 8'hAA, 8, h);
        total++;
        if (h !== 8'h30) $display("FAIL simul_strobe got %h want 30", h);
        else passed++;
        total++;
        if (do_a !== 16'hAA55) $display("FAIL simul_word got %h want aa55", do_a);
        else passed++;
        @(negedge clk) ea = 2'b00;
        repeat (6) @(negedge clk);
        total++;
        if (consec !== 0) $display("FAIL consec_den got %0d want 0", consec);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_basic();
        test_lsb_falling();
        test_frame_err();
        test_en_low();
        test_reset_midword();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
